lcd_write_sequencer: RTL

//  Downstream consumer of the CPU's memory-mapped LCD byte writes. Takes (rs, byte) requests via valid/ready.

---
 rtl/lcd_pkg.sv | 27 ++
 rtl/lcd_req_fifo.sv | 44 ++++
 rtl/lcd_write_sequencer.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/lcd_pkg.sv
// Shared types for the HD44780 write sequencer: FSM states, request record, command codes.
package lcd_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StPulse,
        StHold,
        StExec
    } lcdState_e;

    typedef struct packed {
        logic       rs;
        logic [7:0] data;
    } lcdReq_t;

    localparam logic [7:0] LCD_CMD_CLEAR    = 8'h01;
    localparam logic [7:0] LCD_CMD_HOME     = 8'h02;
    // The controller ignores bit 0 of return-home, so 8'h03 is also a home command.
    localparam logic [7:0] LCD_CMD_HOME_ALT = 8'h03;

    // Clear and return-home need the long execution wait.
    function automatic logic isLongCmd(lcdReq_t req);
        return !req.rs && (req.data inside {LCD_CMD_CLEAR, LCD_CMD_HOME, LCD_CMD_HOME_ALT});
    endfunction

endpackage

// File: rtl/lcd_req_fifo.sv
// Synchronous request FIFO; full/empty come from an extra wrap bit on each pointer.
module lcd_req_fifo
    import lcd_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    push,
    input  lcdReq_t pushReq,
    input  logic    pop,
    output lcdReq_t popReq,
    output logic    full,
    output logic    empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    lcdReq_t       mem [DEPTH];
    logic [AW:0]   wrPtrQ, rdPtrQ;
    logic          doPush, doPop;

    assign doPush = push && !full;
    assign doPop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtrQ <= '0;
            rdPtrQ <= '0;
        end else begin
            if (doPush) wrPtrQ <= wrPtrQ + (AW + 1)'(1);
            if (doPop)  rdPtrQ <= rdPtrQ + (AW + 1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (doPush) mem[wrPtrQ[AW-1:0]] <= pushReq;
    end

    assign popReq = mem[rdPtrQ[AW-1:0]];
    assign empty  = (wrPtrQ == rdPtrQ);
    assign full   = (wrPtrQ[AW] != rdPtrQ[AW]) && (wrPtrQ[AW-1:0] == rdPtrQ[AW-1:0]);

endmodule

// File: rtl/lcd_write_sequencer.sv
// HD44780 8-bit write sequencer: setup, E pulse, hold, execution wait per byte.
// Define LCD_FIFO_EN to buffer requests in an lcd_req_fifo instead of a single latch.
module lcd_write_sequencer
    import lcd_pkg::*;
#(
    parameter int unsigned SETUP_CYCLES     = 2,
    parameter int unsigned PULSE_CYCLES     = 12,
    parameter int unsigned HOLD_CYCLES      = 2,
    parameter int unsigned EXEC_CYCLES      = 2000,
    parameter int unsigned LONG_EXEC_CYCLES = 80000,
    parameter int unsigned CNT_W            = 20,
    parameter int unsigned FIFO_DEPTH       = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_valid,
    input  logic        wr_rs,
    input  logic [7:0]  wr_data,
    output logic        wr_ready,
    output logic        busy,
    output logic [10:0] lcd_pins
);

    localparam int unsigned MaxA = (SETUP_CYCLES > PULSE_CYCLES) ? SETUP_CYCLES : PULSE_CYCLES;
    localparam int unsigned MaxB = (HOLD_CYCLES > EXEC_CYCLES) ? HOLD_CYCLES : EXEC_CYCLES;
    localparam int unsigned MaxC = (MaxA > MaxB) ? MaxA : MaxB;
    localparam int unsigned MaxCycles = (MaxC > LONG_EXEC_CYCLES) ? MaxC : LONG_EXEC_CYCLES;

    if (SETUP_CYCLES < 1 || PULSE_CYCLES < 1 || HOLD_CYCLES < 1 || EXEC_CYCLES < 1 ||
        LONG_EXEC_CYCLES < 1) begin : gBadCycles
        $error("all *_CYCLES parameters must be >= 1");
    end
    if (CNT_W < 1 || CNT_W > 31 || ((MaxCycles - 1) >> CNT_W) != 0) begin : gBadCntW
        $error("CNT_W too narrow for the longest phase");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : gBadDepth
        $error("FIFO_DEPTH must be a power of two >= 2");
    end

    lcdState_e        stateQ, stateD;
    logic [CNT_W-1:0] cntQ, cntD;
    logic             eQ, eD;
    lcdReq_t          reqQ, reqD;
    lcdReq_t          reqIn;
    logic             reqAvail;
    logic             cntZero;

`ifdef LCD_FIFO_EN
    logic    fifoFull, fifoEmpty;
    lcdReq_t pushReq;

    assign pushReq = '{rs: wr_rs, data: wr_data};

    // Pop only from IDLE, so a freshly pushed entry always waits one edge.
    lcd_req_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) uReqFifo (
        .clk     (clk),
        .rst     (rst),
        .push    (wr_valid),
        .pushReq (pushReq),
        .pop     (stateQ == StIdle),
        .popReq  (reqIn),
        .full    (fifoFull),
        .empty   (fifoEmpty)
    );

    assign reqAvail = !fifoEmpty;
    assign wr_ready = !fifoFull;
    assign busy     = (stateQ != StIdle) || !fifoEmpty;
`else
    assign reqIn    = '{rs: wr_rs, data: wr_data};
    assign reqAvail = wr_valid;
    assign wr_ready = (stateQ == StIdle);
    assign busy     = (stateQ != StIdle);
`endif

    assign cntZero = (cntQ == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            stateQ <= StIdle;
            cntQ   <= '0;
            eQ     <= 1'b0;
            reqQ   <= '0;
        end else begin
            stateQ <= stateD;
            cntQ   <= cntD;
            eQ     <= eD;
            reqQ   <= reqD;
        end
    end

    always_comb begin
        stateD = stateQ;
        cntD   = cntQ;
        unique case (stateQ)
            StIdle: begin
                if (reqAvail) begin
                    stateD = StSetup;
                    cntD   = CNT_W'(SETUP_CYCLES - 1);
                end
            end
            StSetup: begin
                if (cntZero) begin
                    stateD = StPulse;
                    cntD   = CNT_W'(PULSE_CYCLES - 1);
                end else begin
                    cntD = cntQ - CNT_W'(1);
                end
            end
            StPulse: begin
                if (cntZero) begin
                    stateD = StHold;
                    cntD   = CNT_W'(HOLD_CYCLES - 1);
                end else begin
                    cntD = cntQ - CNT_W'(1);
                end
            end
            StHold: begin
                if (cntZero) begin
                    stateD = StExec;
                    cntD   = isLongCmd(reqQ) ? CNT_W'(LONG_EXEC_CYCLES - 1)
                                             : CNT_W'(EXEC_CYCLES - 1);
                end else begin
                    cntD = cntQ - CNT_W'(1);
                end
            end
            StExec: begin
                if (cntZero) begin
                    stateD = StIdle;
                end else begin
                    cntD = cntQ - CNT_W'(1);
                end
            end
            default: begin
                stateD = StIdle;
                cntD   = '0;
            end
        endcase
    end

    // rs/data stay latched from SETUP entry until the next request is taken.
    always_comb begin
        eD   = (stateD == StPulse);
        reqD = reqQ;
        if (stateQ == StIdle && reqAvail) begin
            reqD = reqIn;
        end
    end

    assign lcd_pins = {eQ, 1'b0, reqQ.rs, reqQ.data};

endmodule
